// File: rtl/nibble_arith_pkg.sv
// Shared definitions for the nibble-serial arithmetic blocks: slice width,
// controller states and an index-width helper.
package nibble_arith_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Ceiling log2, never below 1 so a counter always has at least one bit.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/cla4_slice.sv
// Combinational 4-bit carry-lookahead slice: every internal carry is a
// two-level function of generate/propagate and the incoming carry.
module cla4_slice
  import nibble_arith_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout,
  output logic                c3,
  output logic                pg,
  output logic                gg
);

  logic [NIBBLE_W-1:0] p;
  logic [NIBBLE_W-1:0] g;
  logic                c1;
  logic                c2;

  assign p = a ^ b;
  assign g = a & b;

  assign c1 = g[0] | (p[0] & cin);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
            | (p[2] & p[1] & p[0] & cin);

  assign pg = &p;
  assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]);

  assign cout = gg | (pg & cin);
  assign s    = p ^ {c3, c2, c1, cin};

endmodule

// File: rtl/nibble_serial_addsub.sv
// WIDTH-bit adder/subtractor that walks one shared 4-bit lookahead slice over
// the operands LSB nibble first, with a start/ready/done handshake.
module nibble_serial_addsub
  import nibble_arith_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);

  localparam int N     = WIDTH / NIBBLE_W;
  localparam int IDX_W = clog2(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_e              state_q;
  logic [IDX_W-1:0]    idx_q;
  logic                carry_q;
  logic                carry_d;
  logic [WIDTH-1:0]    opA_q;
  logic [WIDTH-1:0]    opB_q;
  logic [WIDTH-1:0]    result_q;
  logic [WIDTH-1:0]    result_d;
  logic                ready_q;
  logic                done_q;
  logic                cOut_q;
  logic                ovf_q;
  logic                zero_q;

  logic [NIBBLE_W-1:0] nibA;
  logic [NIBBLE_W-1:0] nibB;
  logic [NIBBLE_W-1:0] sliceSum;
  logic                sliceCout;
  logic                sliceC3;
  logic                slicePg;
  logic                sliceGg;

  // opB_q already holds ~b for subtraction, so the slice only ever adds.
  always_comb begin
    nibA = '0;
    nibB = '0;
    for (int k = 0; k < N; k++) begin
      if (idx_q == IDX_W'(k)) begin
        nibA = opA_q[k*NIBBLE_W +: NIBBLE_W];
        nibB = opB_q[k*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  cla4_slice u_slice (
    .a    (nibA),
    .b    (nibB),
    .cin  (carry_q),
    .s    (sliceSum),
    .cout (sliceCout),
    .c3   (sliceC3),
    .pg   (slicePg),
    .gg   (sliceGg)
  );

  always_comb begin
    result_d = result_q;
    for (int k = 0; k < N; k++) begin
      if (idx_q == IDX_W'(k)) begin
        result_d[k*NIBBLE_W +: NIBBLE_W] = sliceSum;
      end
    end
  end

  // Inter-nibble carry taken from the group terms so it is one AND-OR past the slice.
  assign carry_d = sliceGg | (slicePg & carry_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      opA_q    <= '0;
      opB_q    <= '0;
      result_q <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      cOut_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            opA_q   <= a;
            opB_q   <= b ^ {WIDTH{sub}};
            carry_q <= sub;
            idx_q   <= '0;
            ready_q <= 1'b0;
            state_q <= RUN;
          end
        end
        RUN: begin
          result_q <= result_d;
          carry_q  <= carry_d;
          if (idx_q == LAST_IDX) begin
            idx_q   <= '0;
            cOut_q  <= sliceCout;
            ovf_q   <= sliceC3 ^ sliceCout;
            zero_q  <= (result_d == '0);
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ready  = ready_q;
  assign done   = done_q;
  assign result = result_q;
  assign c_out  = cOut_q;
  assign ovf    = ovf_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Bench for nibble_serial_addsub: directed corner cases plus random operands
// compared against a plain-arithmetic reference model.
module tb_nibble_serial_addsub;

  localparam int WIDTH = 16;
  localparam int N     = WIDTH / 4;

  logic             clk;
  logic             rst;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             c_out;
  logic             ovf;
  logic             zero;

  int checks = 0;
  int errors = 0;

  nibble_serial_addsub #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .ready  (ready),
    .done   (done),
    .result (result),
    .c_out  (c_out),
    .ovf    (ovf),
    .zero   (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference: whole-word arithmetic, overflow judged from operand/result signs.
  task automatic model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic sv,
                       output logic [WIDTH-1:0] r, output logic c, output logic o, output logic z);
    logic [WIDTH:0] wide;
    if (sv) wide = {1'b0, av} + {1'b0, ~bv} + 17'd1;
    else    wide = {1'b0, av} + {1'b0, bv};
    r = wide[WIDTH-1:0];
    c = wide[WIDTH];
    if (sv) o = (av[WIDTH-1] != bv[WIDTH-1]) && (r[WIDTH-1] != av[WIDTH-1]);
    else    o = (av[WIDTH-1] == bv[WIDTH-1]) && (r[WIDTH-1] != av[WIDTH-1]);
    z = (r == '0);
  endtask

  // Called #1 after an edge; returns #1 after the accepting edge T.
  task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic sv);
    int waited;
    waited = 0;
    while (ready !== 1'b1 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    check("ready_before_start", {31'd0, ready}, 32'd1);
    a = av; b = bv; sub = sv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
    check("ready_after_accept", {31'd0, ready}, 32'd0);
  endtask

  // done is visible in the cycle after edge T+N, i.e. N edges after T.
  task automatic checkOutput(input string tag, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic sv);
    logic [WIDTH-1:0] er;
    logic ec, eo, ez;
    int edges;
    model(av, bv, sv, er, ec, eo, ez);
    edges = 0;
    while (done !== 1'b1 && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    check({tag, "_latency"}, edges, N);
    check({tag, "_result"}, {16'd0, result}, {16'd0, er});
    check({tag, "_c_out"}, {31'd0, c_out}, {31'd0, ec});
    check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
    check({tag, "_zero"}, {31'd0, zero}, {31'd0, ez});
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    check({tag, "_ready_back"}, {31'd0, ready}, 32'd1);
    check({tag, "_result_held"}, {16'd0, result}, {16'd0, er});
  endtask

  initial begin
    logic [WIDTH-1:0] av, bv, er, firstResult;
    logic sv, ec, eo, ez;
    int dones, readyEarly, lastDone, doneCount;

    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    @(posedge clk); @(posedge clk); #1;
    check("reset_ready", {31'd0, ready}, 32'd1);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", {16'd0, result}, 32'd0);
    check("reset_flags", {29'd0, c_out, ovf, zero}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    applyStimulus(16'h0001, 16'h0000, 1'b0); checkOutput("add_basic", 16'h0001, 16'h0000, 1'b0);
    applyStimulus(16'hFFFF, 16'h0001, 1'b0); checkOutput("add_wrap", 16'hFFFF, 16'h0001, 1'b0);
    applyStimulus(16'h7FFF, 16'h0001, 1'b0); checkOutput("add_ovf", 16'h7FFF, 16'h0001, 1'b0);
    applyStimulus(16'h0005, 16'h0007, 1'b1); checkOutput("sub_borrow", 16'h0005, 16'h0007, 1'b1);
    applyStimulus(16'h8000, 16'h0001, 1'b1); checkOutput("sub_ovf", 16'h8000, 16'h0001, 1'b1);
    applyStimulus(16'h1234, 16'h1234, 1'b1); checkOutput("sub_zero", 16'h1234, 16'h1234, 1'b1);

    // Busy rejection: a second start during RUN must be dropped.
    applyStimulus(16'h0F0F, 16'h00F1, 1'b0);
    @(posedge clk); #1;
    a = 16'h1111; b = 16'h2222; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0; readyEarly = 0; firstResult = '0;
    for (int i = 0; i < 15; i++) begin
      if (done === 1'b1) begin
        if (dones == 0) firstResult = result;
        dones++;
      end
      if (dones == 0 && ready !== 1'b0) readyEarly++;
      @(posedge clk); #1;
    end
    check("busy_done_count", dones, 1);
    check("busy_result", {16'd0, firstResult}, 32'h1000);
    check("busy_ready_low", readyEarly, 0);

    // Reset on edge T+2 aborts the operation.
    applyStimulus(16'h4321, 16'h1111, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_ready", {31'd0, ready}, 32'd1);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_result", {16'd0, result}, 32'd0);
    check("abort_flags", {29'd0, c_out, ovf, zero}, 32'd0);
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    check("abort_no_done", dones, 0);
    applyStimulus(16'h4321, 16'h1111, 1'b0); checkOutput("after_abort", 16'h4321, 16'h1111, 1'b0);

    // Back-to-back: start held high gives one result every N+2 cycles.
    a = 16'hABCD; b = 16'h1111; sub = 1'b0; start = 1'b1;
    doneCount = 0; lastDone = -1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        check("b2b_result", {16'd0, result}, 32'hBCDE);
        if (lastDone >= 0) check("b2b_interval", i - lastDone, N + 2);
        lastDone = i;
        doneCount++;
      end
    end
    check("b2b_done_count", doneCount, 3);
    start = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      av = 16'($urandom); bv = 16'($urandom); sv = 1'($urandom);
      if (i == 0) bv = av;
      applyStimulus(av, bv, sv);
      checkOutput("random", av, bv, sv);
    end
    model(16'h0000, 16'h0000, 1'b0, er, ec, eo, ez);
    applyStimulus(16'h0000, 16'h0000, 1'b0); checkOutput("add_zero", 16'h0000, 16'h0000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
